// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB-Lite transfer/burst encodings and burst-length helper used by the bus fabric.
package AHP_MASTER_PKG;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } HBURST_t;

  localparam int unsigned BEATS_W = 5;

  // Address beats still to issue after the NONSEQ beat of a burst.
  function automatic logic [BEATS_W-1:0] burst_beats(input HBURST_t b);
    logic [BEATS_W-1:0] n;
    case (b)
      WRAP4,  INCR4:  n = 5'd3;
      WRAP8,  INCR8:  n = 5'd7;
      WRAP16, INCR16: n = 5'd15;
      default:        n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_picker.sv
// Round-robin picker: first requester found searching upward from last+1, wrapping modulo N_MST.
module ahb_rr_picker #(
  parameter int unsigned N_MST = 2,
  parameter int unsigned MW    = (N_MST > 1) ? $clog2(N_MST) : 1
) (
  input  logic [N_MST-1:0] req,
  input  logic [MW-1:0]    last,
  output logic [N_MST-1:0] gnt,
  output logic [MW-1:0]    idx,
  output logic             any
);

  int unsigned cand;

  // Walk from the farthest slot to the nearest so the nearest requester is written last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = N_MST; off > 0; off--) begin
      cand = (32'(last) + off) % N_MST;
      if (req[cand]) begin
        idx = cand[MW-1:0];
        any = 1'b1;
      end
    end
    gnt      = '0;
    gnt[idx] = any;
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite multi-master arbiter: round-robin grant at legal boundaries, keeping fixed bursts,
// locked sequences and undefined-length INCR bursts intact; tracks address- and data-phase owners.
module ahb_bus_arbiter
  import AHP_MASTER_PKG::*;
#(
  parameter int unsigned N_MST = 2,
  parameter int unsigned MW    = (N_MST > 1) ? $clog2(N_MST) : 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [N_MST-1:0] HBUSREQ,
  input  logic [N_MST-1:0] HLOCK,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HBURST,
  input  logic             HREADY,
  output logic [N_MST-1:0] HGRANT,
  output logic [MW-1:0]    HMASTER,
  output logic [MW-1:0]    HMASTER_D,
  output logic             HMASTLOCK
);

  logic [N_MST-1:0]   grant_q,    grant_d;
  logic [MW-1:0]      master_q,   master_d;
  logic [MW-1:0]      master_dp_q, master_dp_d;
  logic               mastlock_q, mastlock_d;
  logic [BEATS_W-1:0] beats_q,    beats_d;
  logic [MW-1:0]      rr_last_q,  rr_last_d;

  logic [N_MST-1:0]   pick_gnt;
  logic [MW-1:0]      pick_idx;
  logic               pick_any;
  logic [MW-1:0]      gidx;
  logic               lock_hold, incr_hold, rearb;
  HTRANS_t            trans;
  HBURST_t            burst;

  ahb_rr_picker #(
    .N_MST (N_MST),
    .MW    (MW)
  ) u_picker (
    .req  (HBUSREQ),
    .last (rr_last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    trans = HTRANS_t'(HTRANS);
    burst = HBURST_t'(HBURST);

    gidx = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (grant_q[i]) gidx = i[MW-1:0];
    end

    beats_d = beats_q;
    if (HREADY) begin
      unique case (trans)
        NONSEQ: beats_d = burst_beats(burst);
        SEQ:    beats_d = (beats_q == '0) ? '0 : beats_q - 1'b1;
        IDLE:   beats_d = '0;
        BUSY:   beats_d = beats_q;
      endcase
    end

    // Owner here is the current address-phase master, judged on its own sampled signals.
    lock_hold = mastlock_q && HLOCK[master_q];
    incr_hold = (burst == INCR) && (trans != IDLE) && HBUSREQ[master_q];
    rearb     = HREADY && (beats_d == '0) && !lock_hold && !incr_hold;

    master_d    = master_q;
    master_dp_d = master_dp_q;
    mastlock_d  = mastlock_q;
    if (HREADY) begin
      master_d    = gidx;
      mastlock_d  = HLOCK[gidx];
      master_dp_d = master_q;
    end

    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    if (rearb) begin
      if (pick_any) begin
        grant_d   = pick_gnt;
        rr_last_d = pick_idx;
      end else begin
        grant_d    = '0;
        grant_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q     <= N_MST'(1);
      master_q    <= '0;
      master_dp_q <= '0;
      mastlock_q  <= 1'b0;
      beats_q     <= '0;
      rr_last_q   <= MW'(N_MST - 1);
    end else begin
      grant_q     <= grant_d;
      master_q    <= master_d;
      master_dp_q <= master_dp_d;
      mastlock_q  <= mastlock_d;
      beats_q     <= beats_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTER_D = master_dp_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (2 masters): hand-derived expectations per edge.
module tb_ahb_bus_arbiter;
  import AHP_MASTER_PKG::*;

  logic       HCLK;
  logic       HRESETn;
  logic [1:0] HBUSREQ;
  logic [1:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HGRANT;
  logic       HMASTER;
  logic       HMASTER_D;
  logic       HMASTLOCK;

  int n_chk  = 0;
  int n_pass = 0;

  ahb_bus_arbiter #(
    .N_MST (2)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic rdy);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = rdy;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       exp_m [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    HRESETn = 1'b0;
    drive(2'b00, 2'b00, IDLE, SINGLE, 1'b1);
    #23;
    check("rst_grant", 8'(HGRANT), 8'h01);
    check("rst_hmaster", 8'(HMASTER), 8'h0);
    check("rst_hmaster_d", 8'(HMASTER_D), 8'h0);
    check("rst_mastlock", 8'(HMASTLOCK), 8'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // No requests: default master keeps the bus
    tick();
    check("idle_grant", 8'(HGRANT), 8'h01);
    check("idle_hmaster", 8'(HMASTER), 8'h0);

    // Both requesting SINGLEs: grant alternates every transfer
    drive(2'b11, 2'b00, NONSEQ, SINGLE, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("alt_grant%0d", k), 8'(HGRANT), 8'(exp_g[k]));
      check($sformatf("alt_hmaster%0d", k), 8'(HMASTER), 8'(exp_m[k]));
      check($sformatf("alt_hmaster_d%0d", k), 8'(HMASTER_D), 8'(exp_d[k]));
    end
    drive(2'b00, 2'b00, IDLE, SINGLE, 1'b1);
    repeat (3) tick();

    // M1 INCR4 while M0 requests: no split
    drive(2'b10, 2'b00, IDLE, SINGLE, 1'b1);
    tick();
    tick();
    check("i4_own_grant", 8'(HGRANT), 8'h02);
    check("i4_own_hmaster", 8'(HMASTER), 8'h1);
    drive(2'b11, 2'b00, NONSEQ, INCR4, 1'b1);
    tick();
    check("i4_b1_grant", 8'(HGRANT), 8'h02);
    check("i4_b1_hmaster_d", 8'(HMASTER_D), 8'h1);
    drive(2'b11, 2'b00, SEQ, INCR4, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("i4_b%0d_grant", k + 2), 8'(HGRANT), 8'h02);
    end
    tick();
    check("i4_b4_grant", 8'(HGRANT), 8'h01);
    check("i4_b4_hmaster_d", 8'(HMASTER_D), 8'h1);
    drive(2'b01, 2'b00, IDLE, INCR4, 1'b1);
    tick();
    check("i4_after_hmaster", 8'(HMASTER), 8'h0);
    tick();
    check("i4_after_hmaster_d", 8'(HMASTER_D), 8'h0);

    // M0 INCR8 with three wait states on beat 2
    drive(2'b11, 2'b00, NONSEQ, INCR8, 1'b1);
    tick();
    check("i8_b1_grant", 8'(HGRANT), 8'h01);
    drive(2'b11, 2'b00, SEQ, INCR8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("i8_wait%0d_grant", k), 8'(HGRANT), 8'h01);
      check($sformatf("i8_wait%0d_hmaster", k), 8'(HMASTER), 8'h0);
    end
    drive(2'b11, 2'b00, SEQ, INCR8, 1'b1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("i8_seq%0d_grant", k), 8'(HGRANT), (k == 6) ? 8'h02 : 8'h01);
    end

    // HREADY low at a boundary freezes grant and owner
    drive(2'b01, 2'b00, IDLE, INCR8, 1'b0);
    tick();
    check("frz_grant", 8'(HGRANT), 8'h02);
    check("frz_hmaster", 8'(HMASTER), 8'h0);
    drive(2'b01, 2'b00, IDLE, INCR8, 1'b1);
    tick();
    check("unfrz_grant", 8'(HGRANT), 8'h01);
    check("unfrz_hmaster", 8'(HMASTER), 8'h1);
    tick();
    tick();

    // Locked SINGLEs by M0 with M1 requesting
    drive(2'b01, 2'b01, NONSEQ, SINGLE, 1'b1);
    tick();
    check("lk_mastlock", 8'(HMASTLOCK), 8'h1);
    check("lk_grant", 8'(HGRANT), 8'h01);
    drive(2'b11, 2'b01, NONSEQ, SINGLE, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("lk_hold%0d_grant", k), 8'(HGRANT), 8'h01);
      check($sformatf("lk_hold%0d_mastlock", k), 8'(HMASTLOCK), 8'h1);
    end
    drive(2'b11, 2'b00, IDLE, SINGLE, 1'b1);
    tick();
    check("lk_rel_grant", 8'(HGRANT), 8'h02);
    check("lk_rel_mastlock", 8'(HMASTLOCK), 8'h0);

    // M1 undefined-length INCR holds while it keeps requesting
    drive(2'b10, 2'b00, IDLE, SINGLE, 1'b1);
    tick();
    drive(2'b11, 2'b00, NONSEQ, INCR, 1'b1);
    tick();
    check("incr_nseq_grant", 8'(HGRANT), 8'h02);
    drive(2'b11, 2'b00, SEQ, INCR, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("incr_seq%0d_grant", k), 8'(HGRANT), 8'h02);
    end
    drive(2'b01, 2'b00, SEQ, INCR, 1'b1);
    tick();
    check("incr_drop_grant", 8'(HGRANT), 8'h01);

    // Reset in the middle of a locked M1 INCR8
    drive(2'b10, 2'b10, IDLE, INCR8, 1'b1);
    tick();
    tick();
    drive(2'b10, 2'b10, NONSEQ, INCR8, 1'b1);
    tick();
    drive(2'b10, 2'b10, SEQ, INCR8, 1'b1);
    tick();
    tick();
    check("mid_grant", 8'(HGRANT), 8'h02);
    check("mid_hmaster", 8'(HMASTER), 8'h1);
    check("mid_hmaster_d", 8'(HMASTER_D), 8'h1);
    check("mid_mastlock", 8'(HMASTLOCK), 8'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_grant", 8'(HGRANT), 8'h01);
    check("arst_hmaster", 8'(HMASTER), 8'h0);
    check("arst_hmaster_d", 8'(HMASTER_D), 8'h0);
    check("arst_mastlock", 8'(HMASTLOCK), 8'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(2'b10, 2'b00, BUSY, INCR8, 1'b1);
    tick();
    check("post_rst_grant", 8'(HGRANT), 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
